cfg_stream_dma: RTL
===================

CFG_STREAM_DMA -- requirements
Module: cfg_stream_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of stream words and of out_data; minimum 8.
REQ-002 SHALL have parameter N_CH, default 4: number of PE write channels, 1..2**(DATA_W-2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input buffer entries, power of two, minimum 2.
REQ-004 SHALL have parameter RESET_DATA, default 8'h32 zero-extended to DATA_W: out_data value after reset.
REQ-005 SHALL have clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have start, input, 1: arms the block to process one buffered command sequence.
REQ-008 SHALL have in_valid, input, 1: in_data holds a valid word.
REQ-009 SHALL have in_data, input, DATA_W: command-stream word.
REQ-010 SHALL have in_ready, output, 1: the block can accept a word.
REQ-011 SHALL have out_wr_en, output, N_CH: one-hot per-channel write strobe.
REQ-012 SHALL have out_data, output, DATA_W: payload for the strobed channel.
REQ-013 SHALL have busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have done, output, 1: one-cycle pulse when an END payload has been written.
REQ-015 SHALL have err, output, 1: sticky flag for an out-of-range channel index.

Function
REQ-016 SHALL accept a word at every rising edge where in_valid and in_ready are both high; in_ready SHALL equal not-FIFO-full, and a pop in the same cycle SHALL NOT make room for a push.
REQ-017 SHALL accept words into the FIFO in every state, IDLE included.
REQ-018 SHALL implement the FSM IDLE -> HEADER (on start) -> PAYLOAD -> HEADER, with PAYLOAD -> IDLE after an END payload.
REQ-019 SHALL, in HEADER with the FIFO non-empty, pop one word, latch opcode = word[DATA_W-1:DATA_W-2] (00 WEIGHT, 01 NEXT_PE/OP, 10 START/OPERAND, 11 END), latch ch = word[DATA_W-3:0], and go to PAYLOAD.
REQ-020 SHALL, in PAYLOAD with the FIFO non-empty, pop one word and register out_data = word and out_wr_en = one-hot(ch) for exactly one cycle.
REQ-021 SHALL, with the FSM already waiting in PAYLOAD, raise out_wr_en in the cycle after the edge following acceptance of the payload word (two-edge latency, no bypass).
REQ-022 SHALL, if ch >= N_CH, set err, pop and discard the payload, and keep out_wr_en all-zero.
REQ-023 SHALL pulse done in the same cycle as the END write, or as the END discard when REQ-022 applies.
REQ-024 SHALL keep out_data unchanged between writes, and keep out_wr_en zero whenever the FIFO is empty.
REQ-025 SHALL ignore start while busy is high.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and track occupancy exactly from 0 to FIFO_DEPTH.

Reset
REQ-027 SHALL, when reset is low at a rising edge, set: FSM IDLE, FIFO empty, out_data = RESET_DATA, out_wr_en = 0, done = 0, err = 0, and clear the dedup registers.
REQ-028 SHALL, on reset mid-sequence, abandon the sequence and discard buffered words, with no further write strobes.

Configuration
REQ-029 SHALL, with CFG_DMA_DEDUP_EN defined, hold a per-channel last-written value (reset RESET_DATA) and suppress out_wr_en when the payload equals that channel's value; the word SHALL still be consumed, and done SHALL still fire for END.
REQ-030 SHALL, without CFG_DMA_DEDUP_EN, write every in-range payload and contain no per-channel storage.

Structure
REQ-031 SHALL take the opcode typedef (2-bit enum) and the FSM state enum from the shared package cgra_pkg.
REQ-032 SHALL instantiate the input buffer as sub-module sync_fifo (parameters DATA_W and FIFO_DEPTH; clk and synchronous active-low reset).

Verification
REQ-033 SHALL cover the basic write: push 8'h01, 8'hA5, pulse start -> out_wr_en = 4'b0010 for one cycle with out_data = 8'hA5; busy stays high.
REQ-034 SHALL cover END: push 8'hC3, 8'h7E after start -> out_wr_en = 4'b1000, out_data = 8'h7E, done pulses, FSM in IDLE next cycle.
REQ-035 SHALL cover a full FIFO: hold in_valid for 6 words with no start -> in_ready low after 4 accepts; after start the words drain in order.
REQ-036 SHALL cover a bad channel: header 8'h05 with N_CH = 4, payload 8'h11 -> no strobe, err = 1 and stays set until reset.
REQ-037 SHALL cover dedup: with CFG_DMA_DEDUP_EN, write 8'h32 to channel 0 after reset -> no strobe; then write 8'h33 -> strobe. Without the macro, both payloads strobe.
REQ-038 SHALL cover reset mid-sequence: assert reset between header and payload -> out_data = 8'h32, in_ready = 1, and no strobe after release.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared CGRA configuration types: command-stream opcodes and the DMA sequencer states.
package cgra_pkg;

    typedef enum logic [1:0] {
        OP_WEIGHT  = 2'b00,
        OP_NEXT_PE = 2'b01,
        OP_START   = 2'b10,
        OP_END     = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HEADER  = 2'b01,
        ST_PAYLOAD = 2'b10
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy count; a pop never frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cfg_stream_dma.sv
// Command-stream DMA: buffers header/payload word pairs and strobes one PE channel per payload.
// Optional macro CFG_DMA_DEDUP_EN suppresses writes that repeat a channel's last value.
module cfg_stream_dma
    import cgra_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              N_CH       = 4,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(8'h32)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [N_CH-1:0]   out_wr_en,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CH_W = DATA_W - 2;

    state_t            state;
    state_t            state_nxt;
    opcode_t           opcode;
    logic [CH_W-1:0]   ch;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              hdr_take;
    logic              pay_take;
    logic              ch_ok;
    logic              dup;
    logic              wr_fire;
    logic [N_CH-1:0]   ch_onehot;

    assign in_ready = !fifo_full;
    assign busy     = (state != ST_IDLE);
    assign fifo_pop = hdr_take || pay_take;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && !fifo_full),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_take  = 1'b0;
        pay_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (!fifo_empty) begin
                    hdr_take  = 1'b1;
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!fifo_empty) begin
                    pay_take  = 1'b1;
                    state_nxt = (opcode == OP_END) ? ST_IDLE : ST_HEADER;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_onehot[i] = (ch == CH_W'(i));
        end
    end

    assign ch_ok = ({1'b0, ch} < (CH_W+1)'(N_CH));

`ifdef CFG_DMA_DEDUP_EN
    logic [DATA_W-1:0] last_val [N_CH];

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_onehot[i] && (last_val[i] == fifo_data)) dup = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) last_val[i] <= RESET_DATA;
        end else if (wr_fire) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_onehot[i]) last_val[i] <= fifo_data;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign wr_fire = pay_take && ch_ok && !dup;

    // Out-of-range or duplicate payloads are still consumed, so done fires on every END.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data  <= RESET_DATA;
            out_wr_en <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            opcode    <= OP_WEIGHT;
            ch        <= '0;
        end else begin
            out_wr_en <= wr_fire ? ch_onehot : '0;
            done      <= pay_take && (opcode == OP_END);
            if (wr_fire) out_data <= fifo_data;
            if (pay_take && !ch_ok) err <= 1'b1;
            if (hdr_take) begin
                opcode <= opcode_t'(fifo_data[DATA_W-1 -: 2]);
                ch     <= fifo_data[CH_W-1:0];
            end
        end
    end

endmodule
